uop_packer: RTL and testbench
=============================

// Module: uop_packer
// PURPOSE
//  Write-side front end of the 4-lane uop queue. Takes the serial uop stream from the
//  decoder/microcode sequencer (valid/ready) and packs each instruction's uops into
//  4-lane rows. Instruction start is lane 0; lanes fill in order 0..3; overflow continues at lane 0 of next row.
//  The last uop of an instruction carries EOI. Drives per-lane data + WR_EN into the queue; honours Q_full.
// PARAMETERS
//  UOP_W    39  uop width
//  EOI_BIT  27  bit index of end-of-instruction flag within a uop
//  CNT_W    16  width of stats counters (UOP_PACKER_STATS_EN only)
// PORTS
//  CLK        in   1      clock; all state on posedge
//  RST_N      in   1      reset, synchronous, active-low
//  flush      in   1      discard partial and pending rows (branch mispredict / redirect)
//  IN_uop     in   UOP_W  incoming uop
//  IN_valid   in   1      IN_uop valid
//  IN_ready   out  1      packer accepts IN_uop this cycle
//  OUT_uop0..3 out UOP_W  lane data to queue lanes 0..3 (registered)
//  WR_EN0..3  out  1      lane write strobes
//  Q_full     in   1      queue full; no lane may be written while high
//  ROWS_CNT   out  CNT_W  rows committed (UOP_PACKER_STATS_EN only)
//  STALL_CNT  out  CNT_W  cycles with pending row blocked by Q_full (UOP_PACKER_STATS_EN only)
// BEHAVIOUR
//  - Reset (RST_N=0 at posedge): OUT_uop0..3 = NOP (39'h0_0800_0000, EOI set), lane_ptr=0,
//    fill_mask=0, pending=0, counters=0. Combinational outputs then: WR_EN*=0, IN_ready=1.
//  - Fill buffer: 4 x UOP_W regs, lane_ptr[1:0], fill_mask[3:0]. Output row: OUT_uop0..3, row_mask[3:0], pending.
//  - Accept = IN_valid & IN_ready. IN_ready = ~flush & (~pending | ~Q_full).
//  - On accept: uop written to fill lane lane_ptr, fill_mask[lane_ptr]=1.
//    Row completes if IN_uop[EOI_BIT]=1 or lane_ptr=3: fill buffer + this uop copied to OUT_uop*,
//    row_mask = fill_mask|this lane, pending=1; fill_mask cleared, lane_ptr=0. Unused lanes keep old data.
//    Otherwise lane_ptr increments.
//  - Commit: WR_ENk = pending & ~Q_full & row_mask[k] (combinational from Q_full). pending clears at
//    posedge where pending & ~Q_full, unless a new row completes same cycle (then pending stays 1 with new row).
//  - Latency: uop completing a row at posedge t -> WR_EN high in cycle t+1 if Q_full=0. Peak 1 uop/cycle.
//  - Q_full high with pending row: WR_EN*=0, IN_ready=0, row held; resumes cycle Q_full falls.
//    Q_full high with no pending row: IN_ready=1 and filling continues until a row completes.
//  - flush (priority over accept and commit): IN_ready=0, WR_EN*=0 that cycle; next posedge
//    clears pending, fill_mask, lane_ptr. OUT_uop* not cleared.
//  - Instruction of >4 uops spans rows; row with lane 3 and no EOI commits with mask 4'b1111.
//  - Reset mid-row or mid-stall: everything dropped, same as reset values.
// CONFIGURATION
//  UOP_PACKER_STATS_EN defined: ROWS_CNT increments on each commit; STALL_CNT increments each cycle
//    pending & Q_full & ~flush. Both wrap at 2^CNT_W; reset to 0; flush does not clear them.
//  Undefined: ROWS_CNT/STALL_CNT ports and counter logic absent; all other behaviour identical.
// STRUCTURE
//  - uop_pkg (shared with queue side): UOP_W, EOI_BIT, NOP constant, lane count (4).
//  - Sub-module uop_packer_stats (two saturating-free counters) instantiated only under the macro.
//  - Rest is flat: fill buffer, output row regs, commit logic.
// TESTING
//  1 Single uop 39'h0_0800_0001 (EOI), Q_full=0 -> next cycle WR_EN=0001, OUT_uop0=39'h0_0800_0001.
//  2 Six uops A..F, EOI on F, back-to-back -> WR_EN=1111 (A..D) then WR_EN=0011 (E,F), no bubbles.
//  3 Pending row, Q_full=1 for 5 cycles, IN_valid=1 -> IN_ready=0 and WR_EN=0 for 5 cycles; one commit on release,
//    no uop lost/duplicated; STALL_CNT=5 with macro.
//  4 Two uops of a 3-uop instr then flush -> no WR_EN; next EOI uop X commits WR_EN=0001, OUT_uop0=X.
//  5 RST_N=0 while row pending and Q_full=1 -> after reset WR_EN=0, IN_ready=1, OUT_uop0..3=NOP.
//  6 10 single-uop EOI instructions at 1/cycle, Q_full=0 -> WR_EN=0001 for 10 consecutive cycles; ROWS_CNT=10.

Source files
------------

// File: rtl/uop_pkg.sv
// Shared uop definitions for the packer (write side) and the uop queue (read side).
package uop_pkg;

  localparam int unsigned UOP_W   = 39;
  localparam int unsigned EOI_BIT = 27;
  localparam int unsigned LANES   = 4;
  localparam int unsigned CNT_W   = 16;

  typedef logic [UOP_W-1:0] uop_t;

  // Idle lane filler: all-zero opcode with end-of-instruction set.
  localparam uop_t NOP = 39'h0_0800_0000;

endpackage

// File: rtl/uop_packer_stats.sv
// Wrapping commit/stall counters for the uop packer (used under UOP_PACKER_STATS_EN).
module uop_packer_stats
  import uop_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             row_commit_i,
  input  logic             stall_i,
  output logic [CNT_W-1:0] rows_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [CNT_W-1:0] rows_q, stall_q;

  // Free-running counters; wrap naturally at 2^CNT_W.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rows_q  <= '0;
      stall_q <= '0;
    end else begin
      if (row_commit_i) rows_q  <= rows_q + 1'b1;
      if (stall_i)      stall_q <= stall_q + 1'b1;
    end
  end

  assign rows_cnt_o  = rows_q;
  assign stall_cnt_o = stall_q;

endmodule

// File: rtl/uop_packer.sv
// Packs the serial uop stream into 4-lane rows for the uop queue.
// Optional stats counters (ROWS_CNT/STALL_CNT) present when UOP_PACKER_STATS_EN is defined.
module uop_packer
  import uop_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             flush,
  input  logic [UOP_W-1:0] IN_uop,
  input  logic             IN_valid,
  output logic             IN_ready,
  output logic [UOP_W-1:0] OUT_uop0,
  output logic [UOP_W-1:0] OUT_uop1,
  output logic [UOP_W-1:0] OUT_uop2,
  output logic [UOP_W-1:0] OUT_uop3,
  output logic             WR_EN0,
  output logic             WR_EN1,
  output logic             WR_EN2,
  output logic             WR_EN3,
  input  logic             Q_full
`ifdef UOP_PACKER_STATS_EN
  ,
  output logic [CNT_W-1:0] ROWS_CNT,
  output logic [CNT_W-1:0] STALL_CNT
`endif
);

  uop_t       fill_q [LANES];
  uop_t       fill_d [LANES];
  uop_t       out_q  [LANES];
  uop_t       out_d  [LANES];
  logic [1:0] lane_ptr_q, lane_ptr_d;
  logic [3:0] fill_mask_q, fill_mask_d;
  logic [3:0] row_mask_q, row_mask_d;
  logic       pending_q, pending_d;
  logic       accept, commit, complete;

  // Handshake and commit qualification; flush overrides both.
  always_comb begin
    IN_ready = ~flush & (~pending_q | ~Q_full);
    accept   = IN_valid & IN_ready;
    commit   = pending_q & ~Q_full & ~flush;
    complete = accept & (IN_uop[EOI_BIT] | (lane_ptr_q == 2'd3));
  end

  // Next state for fill buffer, output row and pending flag.
  // A commit and a new row completion in the same cycle leave pending set with the new row.
  always_comb begin
    fill_d      = fill_q;
    out_d       = out_q;
    lane_ptr_d  = lane_ptr_q;
    fill_mask_d = fill_mask_q;
    row_mask_d  = row_mask_q;
    pending_d   = pending_q;
    if (flush) begin
      pending_d   = 1'b0;
      fill_mask_d = '0;
      lane_ptr_d  = '0;
    end else begin
      if (commit) pending_d = 1'b0;
      if (accept) begin
        fill_d[lane_ptr_q] = IN_uop;
        if (complete) begin
          for (int unsigned k = 0; k < LANES; k++) begin
            if (fill_mask_q[k]) out_d[k] = fill_q[k];
          end
          out_d[lane_ptr_q] = IN_uop;
          row_mask_d        = fill_mask_q | (4'b0001 << lane_ptr_q);
          pending_d         = 1'b1;
          fill_mask_d       = '0;
          lane_ptr_d        = '0;
        end else begin
          fill_mask_d[lane_ptr_q] = 1'b1;
          lane_ptr_d              = lane_ptr_q + 2'd1;
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        fill_q[k] <= '0;
        out_q[k]  <= NOP;
      end
      lane_ptr_q  <= '0;
      fill_mask_q <= '0;
      row_mask_q  <= '0;
      pending_q   <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      out_q       <= out_d;
      lane_ptr_q  <= lane_ptr_d;
      fill_mask_q <= fill_mask_d;
      row_mask_q  <= row_mask_d;
      pending_q   <= pending_d;
    end
  end

  assign OUT_uop0 = out_q[0];
  assign OUT_uop1 = out_q[1];
  assign OUT_uop2 = out_q[2];
  assign OUT_uop3 = out_q[3];

  assign WR_EN0 = commit & row_mask_q[0];
  assign WR_EN1 = commit & row_mask_q[1];
  assign WR_EN2 = commit & row_mask_q[2];
  assign WR_EN3 = commit & row_mask_q[3];

`ifdef UOP_PACKER_STATS_EN
  uop_packer_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk_i        (CLK),
    .rst_ni       (RST_N),
    .row_commit_i (commit),
    .stall_i      (pending_q & Q_full & ~flush),
    .rows_cnt_o   (ROWS_CNT),
    .stall_cnt_o  (STALL_CNT)
  );
`endif

endmodule

// File: tb/tb_uop_packer.sv
// Self-checking bench for uop_packer: directed scenarios plus a randomized run,
// all compared against a row-level reference model built from queues.
module tb_uop_packer;
  import uop_pkg::*;

  logic             CLK = 1'b0;
  logic             RST_N, flush, IN_valid, IN_ready, Q_full;
  logic [UOP_W-1:0] IN_uop, OUT_uop0, OUT_uop1, OUT_uop2, OUT_uop3;
  logic             WR_EN0, WR_EN1, WR_EN2, WR_EN3;
`ifdef UOP_PACKER_STATS_EN
  logic [CNT_W-1:0] ROWS_CNT, STALL_CNT;
`endif

  always #5 CLK = ~CLK;

  uop_packer dut (
    .CLK(CLK), .RST_N(RST_N), .flush(flush),
    .IN_uop(IN_uop), .IN_valid(IN_valid), .IN_ready(IN_ready),
    .OUT_uop0(OUT_uop0), .OUT_uop1(OUT_uop1), .OUT_uop2(OUT_uop2), .OUT_uop3(OUT_uop3),
    .WR_EN0(WR_EN0), .WR_EN1(WR_EN1), .WR_EN2(WR_EN2), .WR_EN3(WR_EN3),
    .Q_full(Q_full)
`ifdef UOP_PACKER_STATS_EN
    , .ROWS_CNT(ROWS_CNT), .STALL_CNT(STALL_CNT)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: uops of the instruction row being gathered, the row
  // waiting for the queue, the last row handed to the queue, and stats.
  logic [UOP_W-1:0] part [$];
  logic [UOP_W-1:0] m_out [4];
  logic [3:0]       m_mask;
  bit               m_pend;
  int unsigned      m_rows, m_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [UOP_W-1:0] rnd_uop(input bit eoi);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    r[EOI_BIT] = eoi;
    return r[UOP_W-1:0];
  endfunction

  task automatic model_reset();
    part.delete();
    m_pend = 0;
    m_mask = '0;
    m_rows = 0;
    m_stall = 0;
    for (int i = 0; i < 4; i++) m_out[i] = 39'h0_0800_0000;
  endtask

  task automatic do_reset(input bit qf);
    @(negedge CLK);
    RST_N = 1'b0; IN_valid = 1'b0; flush = 1'b0; Q_full = qf; IN_uop = '0;
    @(posedge CLK);
    model_reset();
  endtask

  // One clock: drive at negedge, check settled outputs, advance model at posedge.
  task automatic step(input bit v, input logic [UOP_W-1:0] u, input bit qf, input bit fl);
    bit rdy, com, stall;
    logic [3:0] we;
    @(negedge CLK);
    RST_N = 1'b1; IN_valid = v; IN_uop = u; Q_full = qf; flush = fl;
    #1;
    rdy   = !fl && (!m_pend || !qf);
    com   = m_pend && !qf && !fl;
    stall = m_pend && qf && !fl;
    we    = com ? m_mask : 4'b0000;
    chk("in_ready", 64'(IN_ready), 64'(rdy));
    chk("wr_en", 64'({WR_EN3, WR_EN2, WR_EN1, WR_EN0}), 64'(we));
    chk("out_uop0", 64'(OUT_uop0), 64'(m_out[0]));
    chk("out_uop1", 64'(OUT_uop1), 64'(m_out[1]));
    chk("out_uop2", 64'(OUT_uop2), 64'(m_out[2]));
    chk("out_uop3", 64'(OUT_uop3), 64'(m_out[3]));
`ifdef UOP_PACKER_STATS_EN
    chk("rows_cnt", 64'(ROWS_CNT), 64'(m_rows % (1 << CNT_W)));
    chk("stall_cnt", 64'(STALL_CNT), 64'(m_stall % (1 << CNT_W)));
`endif
    @(posedge CLK);
    if (stall) m_stall++;
    if (fl) begin
      part.delete();
      m_pend = 0;
    end else begin
      if (com) begin
        m_pend = 0;
        m_rows++;
      end
      if (v && rdy) begin
        part.push_back(u);
        if (u[EOI_BIT] || part.size() == 4) begin
          for (int i = 0; i < part.size(); i++) m_out[i] = part[i];
          m_mask = 4'((1 << part.size()) - 1);
          m_pend = 1;
          part.delete();
        end
      end
    end
  endtask

  logic [UOP_W-1:0] x;

  initial begin
    RST_N = 1'b0; flush = 1'b0; IN_valid = 1'b0; Q_full = 1'b0; IN_uop = '0;
    model_reset();
    do_reset(1'b0);

    // 1: single EOI uop, commit next cycle on lane 0.
    step(1, 39'h0_0800_0001, 0, 0);
    step(0, '0, 0, 0);
    chk("t1_lane0", 64'(OUT_uop0), 64'h0_0800_0001);

    // 2: six-uop instruction spanning two rows, back-to-back.
    for (int i = 0; i < 6; i++) step(1, rnd_uop(i == 5), 0, 0);
    step(0, '0, 0, 0);
    step(0, '0, 0, 0);

    // 3: pending row held by Q_full for 5 cycles with input waiting.
    step(1, rnd_uop(1), 0, 0);
    for (int i = 0; i < 5; i++) step(1, rnd_uop(1), 1, 0);
    step(1, rnd_uop(1), 0, 0);
    step(0, '0, 0, 0);
`ifdef UOP_PACKER_STATS_EN
    chk("t3_stall", 64'(STALL_CNT), 64'd5);
`endif

    // 4: partial instruction flushed, then a fresh single-uop instruction.
    step(1, rnd_uop(0), 0, 0);
    step(1, rnd_uop(0), 0, 0);
    step(1, rnd_uop(1), 0, 1);
    x = rnd_uop(1);
    step(1, x, 0, 0);
    step(0, '0, 0, 0);
    chk("t4_lane0", 64'(OUT_uop0), 64'(x));

    // 5: reset while a row is pending and the queue is full.
    step(1, rnd_uop(1), 0, 0);
    step(0, '0, 1, 0);
    do_reset(1'b1);
    step(0, '0, 1, 0);
    chk("t5_nop0", 64'(OUT_uop0), 64'h0_0800_0000);

    // 6: ten single-uop instructions at full rate.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) step(1, rnd_uop(1), 0, 0);
    step(0, '0, 0, 0);
`ifdef UOP_PACKER_STATS_EN
    chk("t6_rows", 64'(ROWS_CNT), 64'd10);
`endif

    // Randomized traffic with back-pressure, flushes and occasional reset.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset(1'($urandom_range(0, 1)));
      else step(1'($urandom_range(0, 3) != 0), rnd_uop($urandom_range(0, 3) == 0),
                $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
